regmode_cfg_ctrl: RTL and testbench

- Configuration controller for a bank of NUM_REGS RegisterMode datapath slices.
- Owns each slice's mode and const_ shadow registers, and sequences one-cycle config_we pulses that load a slice's internal register.
- Reads back mode, const_ or live register value over a single valid/ready request/response port.
- Freezes clk_en of the slice being accessed for the duration of a transaction.

---
 rtl/regmode_cfg_pkg.sv | 28 ++
 rtl/regmode_cfg_ctrl_if.sv | 29 ++
 rtl/regmode_cfg_bank.sv | 62 ++++++
 rtl/regmode_cfg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_regmode_cfg_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regmode_cfg_pkg.sv
// Shared types and constants for the RegisterMode configuration controller.
//   field_e : address field selector (low two bits of cfg_addr)
//   state_e : request FSM states
//   MODE_*  : mode encodings understood by the datapath slices
//   idx_width(): slice index width derived from the slice count (minimum 1)
package regmode_cfg_pkg;

    typedef enum logic [1:0] {
        FLD_MODE  = 2'd0,
        FLD_CONST = 2'd1,
        FLD_VALUE = 2'd2,
        FLD_RSVD  = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] MODE_CONST  = 2'h0;
    localparam logic [1:0] MODE_BYPASS = 2'h1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regmode_cfg_ctrl_if.sv
// Request/response bus of the configuration controller.
//   cfg_valid/cfg_ready  : request handshake, with cfg_write, cfg_addr
//                          ({slice index, field}) and cfg_wdata
//   rsp_valid/rsp_ready  : response handshake, with rsp_rdata and rsp_err
// master = requester side, slave = controller side.
interface regmode_cfg_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_addr;
    logic [WIDTH-1:0]  cfg_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    modport master (
        output cfg_valid, cfg_write, cfg_addr, cfg_wdata, rsp_ready,
        input  cfg_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cfg_valid, cfg_write, cfg_addr, cfg_wdata, rsp_ready,
        output cfg_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/regmode_cfg_bank.sv
// Per-slice mode/const_ shadow register file.
//   CLK, RESET  : clock, synchronous active-high reset
//   we_mode     : write mode[idx] <= wdata[1:0]
//   we_const    : write const[idx] <= wdata
//   idx, wdata  : shared write/read slice index and write data
//   mode_out    : all modes, slice i at [2i+1:2i]
//   const_out   : all const_ values, slice i at [WIDTH*i +: WIDTH]
//   rd_mode, rd_const : read mux of slice idx
module regmode_cfg_bank
    import regmode_cfg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int WIDTH    = 4,
    parameter int IDX_W    = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      we_mode,
    input  logic                      we_const,
    input  logic [IDX_W-1:0]          idx,
    input  logic [WIDTH-1:0]          wdata,
    output logic [2*NUM_REGS-1:0]     mode_out,
    output logic [WIDTH*NUM_REGS-1:0] const_out,
    output logic [1:0]                rd_mode,
    output logic [WIDTH-1:0]          rd_const
);

    logic [NUM_REGS-1:0][1:0]       mode_q;
    logic [NUM_REGS-1:0][WIDTH-1:0] const_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mode_q[i]  <= MODE_CONST;
                const_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (we_mode && idx == IDX_W'(i))
                    mode_q[i] <= wdata[1:0];
                if (we_const && idx == IDX_W'(i))
                    const_q[i] <= wdata;
            end
        end
    end

    // Loop mux so an index past NUM_REGS reads zero instead of out of range.
    always_comb begin
        rd_mode  = '0;
        rd_const = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_mode  = mode_q[i];
                rd_const = const_q[i];
            end
        end
    end

    assign mode_out  = mode_q;
    assign const_out = const_q;

endmodule

// File: rtl/regmode_cfg_ctrl.sv
// Configuration controller for a bank of RegisterMode datapath slices.
// Owns the mode/const_ shadows, issues one-cycle config_we pulses, reads
// back mode, const_ or live register value, and freezes clk_en of the slice
// under access until its response is taken.
//   CLK, RESET      : clock, synchronous active-high reset
//   run             : global datapath run enable
//   cfg             : request/response bus (slave side)
//   mode_out        : per-slice mode, slice i at [2i+1:2i]
//   const_out       : per-slice const_
//   config_we_out   : one-hot config load pulse (EXEC cycle only)
//   config_data_out : shared config data, holds between writes
//   clk_en_out      : per-slice clk_en = run && !frozen
//   reg_value_in    : per-slice live register value
module regmode_cfg_ctrl
    import regmode_cfg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int WIDTH    = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      run,
    regmode_cfg_ctrl_if.slave         cfg,
    output logic [2*NUM_REGS-1:0]     mode_out,
    output logic [WIDTH*NUM_REGS-1:0] const_out,
    output logic [NUM_REGS-1:0]       config_we_out,
    output logic [WIDTH-1:0]          config_data_out,
    output logic [NUM_REGS-1:0]       clk_en_out,
    input  logic [WIDTH*NUM_REGS-1:0] reg_value_in
);

    localparam int IDX_W  = idx_width(NUM_REGS);
    localparam int ADDR_W = IDX_W + 2;

    state_e state_q, state_d;

    logic                       lat_write;
    logic [IDX_W-1:0]           lat_idx;
    field_e                     lat_field;
    logic [WIDTH-1:0]           lat_wdata;
    logic                       lat_idx_ok;

    logic [NUM_REGS-1:0]        freeze_q;
    logic                       rsp_valid_q;
    logic [WIDTH-1:0]           rsp_rdata_q;
    logic                       rsp_err_q;

    logic [IDX_W-1:0]           in_idx;
    field_e                     in_field;
    logic                       in_idx_ok;
    logic [NUM_REGS-1:0]        in_onehot;
    logic                       accept;

    logic                       we_mode, we_const;
    logic [WIDTH-1:0]           rd_data_d;
    logic                       rd_err_d;
    logic [1:0]                 rd_mode;
    logic [WIDTH-1:0]           rd_const;
    logic [NUM_REGS-1:0][WIDTH-1:0] reg_vals;

    assign reg_vals  = reg_value_in;
    assign in_idx    = cfg.cfg_addr[ADDR_W-1:2];
    assign in_field  = field_e'(cfg.cfg_addr[1:0]);
    assign in_idx_ok = 32'(in_idx) < NUM_REGS;
    // Out-of-range indices shift the bit off the top, giving an empty mask.
    assign in_onehot = NUM_REGS'(1) << in_idx;

    assign cfg.cfg_ready = (state_q == IDLE) && !RESET;
    assign accept        = (state_q == IDLE) && cfg.cfg_valid && !RESET;

    assign cfg.rsp_valid = rsp_valid_q;
    assign cfg.rsp_rdata = rsp_rdata_q;
    assign cfg.rsp_err   = rsp_err_q;

    assign clk_en_out = {NUM_REGS{run}} & ~freeze_q;

    always_comb begin
        state_d   = state_q;
        we_mode   = 1'b0;
        we_const  = 1'b0;
        rd_data_d = '0;
        rd_err_d  = !lat_idx_ok || (lat_field == FLD_RSVD);
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = EXEC;
            end
            EXEC: begin
                state_d  = RESP;
                we_mode  = lat_write && lat_idx_ok && (lat_field == FLD_MODE);
                we_const = lat_write && lat_idx_ok && (lat_field == FLD_CONST);
                if (!lat_write && !rd_err_d) begin
                    case (lat_field)
                        FLD_MODE:  rd_data_d[1:0] = rd_mode;
                        FLD_CONST: rd_data_d = rd_const;
                        FLD_VALUE: begin
                            for (int unsigned i = 0; i < NUM_REGS; i++)
                                if (lat_idx == IDX_W'(i))
                                    rd_data_d = reg_vals[i];
                        end
                        default:   rd_data_d = '0;
                    endcase
                end
            end
            RESP: begin
                if (cfg.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            lat_write       <= 1'b0;
            lat_idx         <= '0;
            lat_field       <= FLD_MODE;
            lat_wdata       <= '0;
            lat_idx_ok      <= 1'b0;
            freeze_q        <= '0;
            config_we_out   <= '0;
            config_data_out <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            config_we_out <= '0;
            if (accept) begin
                lat_write  <= cfg.cfg_write;
                lat_idx    <= in_idx;
                lat_field  <= in_field;
                lat_wdata  <= cfg.cfg_wdata;
                lat_idx_ok <= in_idx_ok;
                if (in_idx_ok)
                    freeze_q <= freeze_q | in_onehot;
                // Pulse is registered at acceptance so it occupies exactly the
                // EXEC cycle and is cleared by reset like any other state.
                if (cfg.cfg_write && in_idx_ok && in_field == FLD_VALUE) begin
                    config_we_out   <= in_onehot;
                    config_data_out <= cfg.cfg_wdata;
                end
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rd_data_d;
                rsp_err_q   <= rd_err_d;
            end
            if (state_q == RESP && cfg.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                freeze_q    <= '0;
            end
        end
    end

    regmode_cfg_bank #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_bank (
        .CLK       (CLK),
        .RESET     (RESET),
        .we_mode   (we_mode),
        .we_const  (we_const),
        .idx       (lat_idx),
        .wdata     (lat_wdata),
        .mode_out  (mode_out),
        .const_out (const_out),
        .rd_mode   (rd_mode),
        .rd_const  (rd_const)
    );

endmodule

// File: tb/tb_regmode_cfg_ctrl.sv
// Self-checking bench for regmode_cfg_ctrl (NUM_REGS = 4, WIDTH = 4).
// Expected responses are queued when a request is issued and popped when
// the response appears on the bus.
module tb_regmode_cfg_ctrl;

    localparam int NR = 4;
    localparam int W  = 4;
    localparam int AW = 4;

    typedef struct packed {
        logic [W-1:0] rd;
        logic         err;
    } exp_t;

    logic              real_clk = 1'b0;
    logic              reset;
    logic              run;
    logic [2*NR-1:0]   mode_out;
    logic [W*NR-1:0]   const_out;
    logic [NR-1:0]     config_we_out;
    logic [W-1:0]      config_data_out;
    logic [NR-1:0]     clk_en_out;
    logic [W*NR-1:0]   reg_value_in;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    regmode_cfg_ctrl_if #(.ADDR_W(AW), .WIDTH(W)) bus ();

    regmode_cfg_ctrl #(.NUM_REGS(NR), .WIDTH(W)) dut (
        .CLK             (real_clk),
        .RESET           (reset),
        .run             (run),
        .cfg             (bus),
        .mode_out        (mode_out),
        .const_out       (const_out),
        .config_we_out   (config_we_out),
        .config_data_out (config_data_out),
        .clk_en_out      (clk_en_out),
        .reg_value_in    (reg_value_in)
    );

    always #5 real_clk = ~real_clk;

    task automatic step();
        @(posedge real_clk);
        #1;
    endtask

    // Presents a request, waits (bounded) for acceptance, returns in EXEC.
    task automatic issue(input bit wr, input logic [1:0] idx, input logic [1:0] fld,
                         input logic [W-1:0] wd, input bit push,
                         input logic [W-1:0] exp_rd, input bit exp_err, output bit to);
        exp_t e;
        e.rd = exp_rd;
        e.err = exp_err;
        if (push) sb.push_back(e);
        bus.cfg_write = wr;
        bus.cfg_addr  = {idx, fld};
        bus.cfg_wdata = wd;
        bus.cfg_valid = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cfg_ready) begin
                to = 1'b0;
                break;
            end
            step();
        end
        step();
        bus.cfg_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid and captures the response.
    task automatic collect(output logic [W-1:0] rd, output logic er, output bit to);
        to = 1'b1;
        rd = '0;
        er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) begin
                rd = bus.rsp_rdata;
                er = bus.rsp_err;
                to = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b1;
        step();
        n_checks++; if (bus.cfg_ready !== 1'b0) $display("FAIL reset_ready_in_reset got %b want 0", bus.cfg_ready); else n_pass++;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (mode_out !== '0) $display("FAIL reset_mode got %h want 0", mode_out); else n_pass++;
        n_checks++; if (const_out !== '0) $display("FAIL reset_const got %h want 0", const_out); else n_pass++;
        n_checks++; if (config_we_out !== '0) $display("FAIL reset_we got %b want 0", config_we_out); else n_pass++;
        n_checks++; if (clk_en_out !== 4'hF) $display("FAIL reset_clken got %b want 1111", clk_en_out); else n_pass++;
        n_checks++; if (bus.cfg_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.cfg_ready); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else n_pass++;
    endtask

    task automatic test_write_const();
        bit to;
        logic [W-1:0] rd;
        logic er;
        exp_t e;
        bus.rsp_ready = 1'b1;
        issue(1'b1, 2'd2, 2'd1, 4'hA, 1'b1, 4'h0, 1'b0, to);
        n_checks++; if (to) $display("FAIL wc_accept_timeout got timeout want accept"); else n_pass++;
        n_checks++; if (const_out !== 16'h0000) $display("FAIL wc_const_exec got %h want 0000", const_out); else n_pass++;
        n_checks++; if (clk_en_out !== 4'b1011) $display("FAIL wc_clken_exec got %b want 1011", clk_en_out); else n_pass++;
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (to) $display("FAIL wc_rsp_timeout got timeout want rsp"); else n_pass++;
        n_checks++; if ({rd, er} !== {e.rd, e.err}) $display("FAIL wc_rsp got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        n_checks++; if (const_out !== 16'h0A00) $display("FAIL wc_const_resp got %h want 0a00", const_out); else n_pass++;
        step();
        n_checks++; if (bus.rsp_valid !== 1'b0 || clk_en_out !== 4'hF) $display("FAIL wc_done got %b/%b want 0/1111", bus.rsp_valid, clk_en_out); else n_pass++;
        issue(1'b0, 2'd2, 2'd1, 4'h0, 1'b1, 4'hA, 1'b0, to);
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL wc_readback got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        step();
    endtask

    task automatic test_value_write();
        bit to;
        logic [W-1:0] rd;
        logic er;
        exp_t e;
        issue(1'b1, 2'd1, 2'd2, 4'h5, 1'b1, 4'h0, 1'b0, to);
        n_checks++; if (config_we_out !== 4'b0010) $display("FAIL vw_we_exec got %b want 0010", config_we_out); else n_pass++;
        n_checks++; if (config_data_out !== 4'h5) $display("FAIL vw_data_exec got %h want 5", config_data_out); else n_pass++;
        n_checks++; if (clk_en_out !== 4'b1101) $display("FAIL vw_clken_exec got %b want 1101", clk_en_out); else n_pass++;
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (config_we_out !== 4'b0000) $display("FAIL vw_we_resp got %b want 0000", config_we_out); else n_pass++;
        n_checks++; if (config_data_out !== 4'h5 || clk_en_out !== 4'b1101) $display("FAIL vw_hold_resp got %h/%b want 5/1101", config_data_out, clk_en_out); else n_pass++;
        n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL vw_rsp got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        step();
        n_checks++; if (clk_en_out !== 4'hF) $display("FAIL vw_clken_done got %b want 1111", clk_en_out); else n_pass++;
    endtask

    task automatic test_stall_read();
        bit to;
        bit stable;
        logic [W-1:0] rd;
        logic er;
        exp_t e;
        reg_value_in = 16'h9000;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 2'd3, 2'd2, 4'h0, 1'b1, 4'h9, 1'b0, to);
        collect(rd, er, to);
        reg_value_in = 16'h2000;
        e = sb.pop_front();
        n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL sr_rsp got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 4'h9 || bus.cfg_ready !== 1'b0 || clk_en_out[3] !== 1'b0)
                stable = 1'b0;
        end
        n_checks++; if (!stable) $display("FAIL sr_stall got v=%b d=%h r=%b want 1/9/0", bus.rsp_valid, bus.rsp_rdata, bus.cfg_ready); else n_pass++;
        bus.rsp_ready = 1'b1;
        step();
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.cfg_ready !== 1'b1) $display("FAIL sr_done got %b/%b want 0/1", bus.rsp_valid, bus.cfg_ready); else n_pass++;
    endtask

    task automatic test_fields();
        bit to;
        bit quiet;
        logic [W-1:0] rd;
        logic er;
        exp_t e;
        issue(1'b0, 2'd0, 2'd3, 4'h0, 1'b1, 4'h0, 1'b1, to);
        quiet = (config_we_out === '0);
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL rsvd_read got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        step();
        issue(1'b1, 2'd0, 2'd3, 4'hF, 1'b1, 4'h0, 1'b1, to);
        quiet = quiet && (config_we_out === '0);
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL rsvd_write got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        step();
        n_checks++; if (!quiet || mode_out !== 8'h00 || const_out !== 16'h0A00) $display("FAIL rsvd_side_effect got %h/%h want 00/0a00", mode_out, const_out); else n_pass++;
        issue(1'b1, 2'd0, 2'd0, 4'h7, 1'b1, 4'h0, 1'b0, to);
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (to || {rd, er} !== {e.rd, e.err} || mode_out !== 8'h03) $display("FAIL mode_write got %h/%b mode %h want 0/0 mode 03", rd, er, mode_out); else n_pass++;
        step();
        issue(1'b0, 2'd0, 2'd0, 4'h0, 1'b1, 4'h3, 1'b0, to);
        collect(rd, er, to);
        e = sb.pop_front();
        n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL mode_read got %h/%b want %h/%b", rd, er, e.rd, e.err); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        bit to;
        bit ok;
        logic [W-1:0] rd;
        logic er;
        logic [W-1:0] d;
        logic [W-1:0] model [NR];
        exp_t e;
        logic [W*NR-1:0] packed_model;
        ok = 1'b1;
        for (int k = 0; k < NR; k++) begin
            d = W'($urandom_range(0, 15));
            model[k] = d;
            issue(1'b1, 2'(k), 2'd1, d, 1'b1, 4'h0, 1'b0, to);
            collect(rd, er, to);
            e = sb.pop_front();
            if (to || {rd, er} !== {e.rd, e.err}) ok = 1'b0;
        end
        step();
        n_checks++; if (!ok) $display("FAIL b2b_write_rsp got %h/%b want 0/0", rd, er); else n_pass++;
        for (int k = NR - 1; k >= 0; k--) begin
            issue(1'b0, 2'(k), 2'd1, 4'h0, 1'b1, model[k], 1'b0, to);
            collect(rd, er, to);
            e = sb.pop_front();
            n_checks++; if (to || {rd, er} !== {e.rd, e.err}) $display("FAIL b2b_read%0d got %h/%b want %h/%b", k, rd, er, e.rd, e.err); else n_pass++;
        end
        step();
        packed_model = {model[3], model[2], model[1], model[0]};
        n_checks++; if (const_out !== packed_model) $display("FAIL b2b_const got %h want %h", const_out, packed_model); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit quiet;
        issue(1'b1, 2'd1, 2'd2, 4'h6, 1'b0, 4'h0, 1'b0, to);
        n_checks++; if (to || config_we_out !== 4'b0010) $display("FAIL rm_exec_we got %b want 0010", config_we_out); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (config_we_out !== '0 || bus.rsp_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        n_checks++; if (!quiet) $display("FAIL rm_quiet got we=%b v=%b want 0/0", config_we_out, bus.rsp_valid); else n_pass++;
        n_checks++; if (mode_out !== '0 || const_out !== '0 || config_data_out !== '0) $display("FAIL rm_shadows got %h/%h/%h want 0/0/0", mode_out, const_out, config_data_out); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL rm_scoreboard got %0d want 0 pending", sb.size()); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b1;
        reg_value_in = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_write = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_wdata = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_write_const();
        test_value_write();
        test_stall_read();
        test_fields();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
